// File: rtl/alu_bist_sequencer.sv
// Built-in self-test sequencer for the 8-bit combinational ALU.
// Walks a fixed 14-entry vector ROM, checks {carry,out} and reports pass, error count and first failing index.
module alu_bist_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [4:0] err_count_o,
  output logic [3:0] fail_idx_o,
  output logic [3:0] alu_ctrl_o,
  output logic [7:0] alu_x_o,
  output logic [7:0] alu_y_o,
  input  logic       alu_carry_i,
  input  logic [7:0] alu_out_i
);

  localparam int unsigned NUM_VEC = 14;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ERR_W   = 5;
  localparam int unsigned ROM_W   = 29;
  localparam logic [IDX_W-1:0] NO_FAIL = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CHECK,
    S_DONE
  } state_t;

  // ROM entry layout: {ctrl[28:25], x[24:17], y[16:9], exp9[8:0]}
  function automatic logic [ROM_W-1:0] rom(input logic [IDX_W-1:0] i);
    case (i)
      4'd0:    rom = {4'h0, 8'hFF, 8'h01, 9'h000};
      4'd1:    rom = {4'h1, 8'h00, 8'h01, 9'h1FF};
      4'd2:    rom = {4'h2, 8'h05, 8'h03, 9'h001};
      4'd3:    rom = {4'h3, 8'h05, 8'h03, 9'h007};
      4'd4:    rom = {4'h4, 8'h01, 8'h00, 9'h0FE};
      4'd5:    rom = {4'h5, 8'h05, 8'h03, 9'h006};
      4'd6:    rom = {4'h6, 8'h05, 8'h03, 9'h0F8};
      4'd7:    rom = {4'h7, 8'h01, 8'h01, 9'h002};
      4'd8:    rom = {4'h8, 8'h01, 8'h80, 9'h040};
      4'd9:    rom = {4'h9, 8'h80, 8'h00, 9'h0C0};
      4'd10:   rom = {4'hA, 8'hC0, 8'h00, 9'h081};
      4'd11:   rom = {4'hB, 8'h81, 8'h00, 9'h0C0};
      4'd12:   rom = {4'hC, 8'hFF, 8'hFF, 9'h001};
      4'd13:   rom = {4'hC, 8'h00, 8'hFF, 9'h000};
      default: rom = '0;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [IDX_W-1:0] fail_q, fail_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [7:0]       x_q, x_d;
  logic [7:0]       y_q, y_d;
  logic [ROM_W-1:0] cur_vec;
  logic [ROM_W-1:0] nxt_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fail_q  <= NO_FAIL;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ctrl_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ctrl_q  <= ctrl_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    ctrl_d  = ctrl_q;
    x_d     = x_q;
    y_d     = y_q;
    cur_vec = rom(idx_q);
    nxt_vec = rom(idx_q + 4'd1);

    case (state_q)
      S_IDLE: begin
        ctrl_d = '0;
        x_d    = '0;
        y_d    = '0;
        if (start_i) begin
          idx_d              = '0;
          cnt_d              = '0;
          err_d              = '0;
          fail_d             = NO_FAIL;
          pass_d             = 1'b0;
          {ctrl_d, x_d, y_d} = rom('0) >> 9;
          state_d            = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CHECK: begin
        // Mismatch lives in the else branch so an X compare counts as a failure.
        if ({alu_carry_i, alu_out_i} == cur_vec[8:0]) begin
          err_d = err_q;
        end else begin
          if (err_q != '1) err_d = err_q + 5'd1;
          if (fail_q == NO_FAIL) fail_d = idx_q;
        end
        if (idx_q == IDX_W'(NUM_VEC - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d              = idx_q + 4'd1;
          {ctrl_d, x_d, y_d} = nxt_vec[ROM_W-1:9];
          state_d            = S_DRIVE;
        end
      end
      S_DONE: begin
        pass_d  = (err_q == '0);
        ctrl_d  = '0;
        x_d     = '0;
        y_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_DRIVE) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
  assign fail_idx_o  = fail_q;
  assign alu_ctrl_o  = ctrl_q;
  assign alu_x_o     = x_q;
  assign alu_y_o     = y_q;

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Scoreboard bench for alu_bist_sequencer: golden ALU with injectable faults,
// expected run results queued at start and compared when done pulses.
module tb_alu_bist_sequencer;

  typedef struct {
    int         dcyc;
    logic       pass;
    logic [4:0] err;
    logic [3:0] fidx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start1, start2;
  int   fault;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  exp_t sbq[$];

  logic       busy1, done1, pass1, carry1;
  logic [4:0] err1;
  logic [3:0] fidx1, ctrl1;
  logic [7:0] x1, y1, out1;
  logic [8:0] gold1;

  logic       busy2, done2, pass2;
  logic [4:0] err2;
  logic [3:0] fidx2, ctrl2;
  logic [7:0] x2, y2;
  logic [8:0] gold2;

  function automatic logic [28:0] tb_rom(input int i);
    case (i)
      0:  tb_rom = {4'h0, 8'hFF, 8'h01, 9'h000};
      1:  tb_rom = {4'h1, 8'h00, 8'h01, 9'h1FF};
      2:  tb_rom = {4'h2, 8'h05, 8'h03, 9'h001};
      3:  tb_rom = {4'h3, 8'h05, 8'h03, 9'h007};
      4:  tb_rom = {4'h4, 8'h01, 8'h00, 9'h0FE};
      5:  tb_rom = {4'h5, 8'h05, 8'h03, 9'h006};
      6:  tb_rom = {4'h6, 8'h05, 8'h03, 9'h0F8};
      7:  tb_rom = {4'h7, 8'h01, 8'h01, 9'h002};
      8:  tb_rom = {4'h8, 8'h01, 8'h80, 9'h040};
      9:  tb_rom = {4'h9, 8'h80, 8'h00, 9'h0C0};
      10: tb_rom = {4'hA, 8'hC0, 8'h00, 9'h081};
      11: tb_rom = {4'hB, 8'h81, 8'h00, 9'h0C0};
      12: tb_rom = {4'hC, 8'hFF, 8'hFF, 9'h001};
      13: tb_rom = {4'hC, 8'h00, 8'hFF, 9'h000};
      default: tb_rom = '0;
    endcase
  endfunction

  // Golden ALU: {carry, out}
  function automatic logic [8:0] alu_model(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    case (c)
      4'h0: alu_model = {1'b0, 8'(x + y)};
      4'h1: alu_model = {x < y, 8'(x - y)};
      4'h2: alu_model = {1'b0, x & y};
      4'h3: alu_model = {1'b0, x | y};
      4'h4: alu_model = {1'b0, ~x};
      4'h5: alu_model = {1'b0, x ^ y};
      4'h6: alu_model = {1'b0, ~(x | y)};
      4'h7: alu_model = {1'b0, x[6:0], 1'b0};
      4'h8: alu_model = {1'b0, 1'b0, y[7:1]};
      4'h9: alu_model = {1'b0, x[7], x[7:1]};
      4'hA: alu_model = {1'b0, x[6:0], x[7]};
      4'hB: alu_model = {1'b0, x[0], x[7:1]};
      4'hC: alu_model = {1'b0, 7'd0, x == y};
      default: alu_model = '0;
    endcase
  endfunction

  function automatic exp_t model_run(input int dcyc, input int f);
    exp_t e;
    logic [28:0] r;
    logic [8:0]  g;
    e.dcyc = dcyc;
    e.err  = '0;
    e.fidx = 4'hF;
    for (int i = 0; i < 14; i++) begin
      r = tb_rom(i);
      g = alu_model(r[28:25], r[24:17], r[16:9]);
      if (f == 1) g[8] = 1'b0;
      if (f == 2) g[7:0] = 8'h00;
      if (g != r[8:0]) begin
        if (e.err != 5'd31) e.err = e.err + 5'd1;
        if (e.fidx == 4'hF) e.fidx = 4'(i);
      end
    end
    e.pass = (e.err == 5'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  assign gold1  = alu_model(ctrl1, x1, y1);
  assign carry1 = (fault == 1) ? 1'b0 : gold1[8];
  assign out1   = (fault == 2) ? 8'h00 : gold1[7:0];
  assign gold2  = alu_model(ctrl2, x2, y2);

  alu_bist_sequencer #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1),
    .err_count_o(err1), .fail_idx_o(fidx1),
    .alu_ctrl_o(ctrl1), .alu_x_o(x1), .alu_y_o(y1),
    .alu_carry_i(carry1), .alu_out_i(out1)
  );

  alu_bist_sequencer #(.SETTLE(3)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .err_count_o(err2), .fail_idx_o(fidx2),
    .alu_ctrl_o(ctrl2), .alu_x_o(x2), .alu_y_o(y2),
    .alu_carry_i(gold2[8]), .alu_out_i(gold2[7:0])
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Done monitor for the SETTLE=1 instance; pass is checked the cycle after done.
  logic pass_pend = 1'b0;
  logic exp_pass;
  always @(negedge clk) begin
    exp_t e;
    if (pass_pend) begin
      chk("pass", 32'(pass1), 32'(exp_pass));
      chk("busy_after_done", 32'(busy1), 32'd0);
      pass_pend = 1'b0;
    end
    if (done1 === 1'b1) begin
      done_cnt++;
      chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("done_cyc", cyc, e.dcyc);
        chk("err_count", 32'(err1), 32'(e.err));
        chk("fail_idx", 32'(fidx1), 32'(e.fidx));
        chk("busy_at_done", 32'(busy1), 32'd0);
        exp_pass  = e.pass;
        pass_pend = 1'b1;
      end
    end
  end

  task automatic wait_done(input int target, input int budget);
    int b = budget;
    while (done_cnt < target && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk("done_timeout", done_cnt, target);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_run1(input bit walk);
    int n = cyc;
    int base = done_cnt;
    logic [28:0] r;
    start1 = 1'b1;
    sbq.push_back(model_run(n + 29, fault));
    @(negedge clk);
    start1 = 1'b0;
    if (walk) begin
      for (int v = 0; v < 14; v++) begin
        r = tb_rom(v);
        for (int k = 0; k < 2; k++) begin
          chk("alu1_vec", 32'({ctrl1, x1, y1}), 32'(r[28:9]));
          chk("busy1", 32'(busy1), 32'd1);
          @(negedge clk);
        end
      end
    end
    wait_done(base + 1, 60);
    chk("alu1_idle", 32'({ctrl1, x1, y1}), 32'd0);
  endtask

  initial begin
    int n;
    int base;
    logic [28:0] r;
    #100000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int base;
    logic [28:0] r;
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; fault = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'({busy1, busy2}), 32'd0);
    chk("rst_done", 32'({done1, done2}), 32'd0);
    chk("rst_pass", 32'({pass1, pass2}), 32'd0);
    chk("rst_err", 32'({err1, err2}), 32'd0);
    chk("rst_fidx", 32'({fidx1, fidx2}), 32'hFF);
    chk("rst_alu", 32'({ctrl1, x1, y1, ctrl2, x2, y2}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // T1 golden, T2 carry stuck 0, T3 out stuck 0
    pulse_run1(1'b1);
    fault = 1;
    pulse_run1(1'b0);
    fault = 2;
    pulse_run1(1'b0);

    // T4 reset mid-run aborts without a done pulse
    fault = 1;
    base = done_cnt;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_err", 32'(err1), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_alu", 32'({ctrl1, x1, y1}), 32'd0);
    chk("abort_err", 32'(err1), 32'd0);
    chk("abort_fidx", 32'(fidx1), 32'hF);
    repeat (40) @(negedge clk);
    chk("abort_no_done", done_cnt, base);
    fault = 0;
    pulse_run1(1'b1);

    // T5 start held high: two back-to-back runs, counters not cleared mid-run
    fault = 1;
    base = done_cnt;
    n = cyc;
    start1 = 1'b1;
    sbq.push_back(model_run(n + 29, fault));
    sbq.push_back(model_run(n + 59, fault));
    repeat (20) @(negedge clk);
    chk("held_err", 32'(err1), 32'd1);
    chk("held_busy", 32'(busy1), 32'd1);
    repeat (25) @(negedge clk);
    start1 = 1'b0;
    wait_done(base + 2, 80);
    repeat (40) @(negedge clk);
    chk("held_two_runs", done_cnt, base + 2);
    chk("sb_drained", sbq.size(), 0);
    fault = 0;

    // T6 SETTLE=3: each vector held 4 cycles, done at t0+57
    chk("s3_pass_before", 32'(pass2), 32'd0);
    n = cyc;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int v = 0; v < 14; v++) begin
      r = tb_rom(v);
      for (int k = 0; k < 4; k++) begin
        chk("alu2_vec", 32'({ctrl2, x2, y2}), 32'(r[28:9]));
        chk("done2_early", 32'(done2), 32'd0);
        @(negedge clk);
      end
    end
    chk("s3_done_cyc", cyc, n + 57);
    chk("s3_done", 32'(done2), 32'd1);
    chk("s3_err", 32'(err2), 32'd0);
    chk("s3_fidx", 32'(fidx2), 32'hF);
    @(negedge clk);
    chk("s3_pass", 32'(pass2), 32'd1);
    chk("s3_done_pulse", 32'(done2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
